// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU memory arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package cpu_pkg;

   // Arbiter states: idle, data access outstanding, instruction access outstanding
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      D_WAIT = 2'd1,
      I_WAIT = 2'd2
   } mem_arb_state_t;

   // Store func3 encodings
   localparam logic [2:0] FUNCT3_SB = 3'b000;
   localparam logic [2:0] FUNCT3_SH = 3'b001;
   localparam logic [2:0] FUNCT3_SW = 3'b010;

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU-side fetch/load/store handshake plus the shared memory bus.
// Latency: none (wiring only).
// Backpressure: CPU is held by stallreq_*; memory completes with mem_ack_i.
interface mem_arbiter_if #(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32
);
   logic                   inst_read_i;
   logic [AddrWidth-1:0]   inst_addr_i;
   logic [DataWidth-1:0]   inst_o;
   logic                   data_read_i;
   logic                   data_write_i;
   logic [2:0]             data_write_type_i;
   logic [AddrWidth-1:0]   data_addr_i;
   logic [DataWidth-1:0]   data_wdata_i;
   logic [DataWidth-1:0]   data_rdata_o;
   logic                   stallreq_from_imem_o;
   logic                   stallreq_from_dmem_o;
   logic                   mem_req_o;
   logic                   mem_we_o;
   logic [AddrWidth-1:0]   mem_addr_o;
   logic [DataWidth-1:0]   mem_wdata_o;
   logic [3:0]             mem_wstrb_o;
   logic                   mem_ack_i;
   logic [DataWidth-1:0]   mem_rdata_i;

   // Arbiter side
   modport master (
      input  inst_read_i, inst_addr_i, data_read_i, data_write_i, data_write_type_i,
             data_addr_i, data_wdata_i, mem_ack_i, mem_rdata_i,
      output inst_o, data_rdata_o, stallreq_from_imem_o, stallreq_from_dmem_o,
             mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
   );

   // Environment side (CPU core and memory)
   modport slave (
      output inst_read_i, inst_addr_i, data_read_i, data_write_i, data_write_type_i,
             data_addr_i, data_wdata_i, mem_ack_i, mem_rdata_i,
      input  inst_o, data_rdata_o, stallreq_from_imem_o, stallreq_from_dmem_o,
             mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
   );
endinterface

// File: rtl/store_align.sv
// Byte-strobe generation and lane replication for SB/SH/SW stores.
// Latency: combinational.
// Backpressure: none.
module store_align
   import cpu_pkg::*;
#(
   parameter int DataWidth = 32
) (
   input  logic                 is_write,
   input  logic [2:0]           write_type,
   input  logic [1:0]           addr_lo,
   input  logic [DataWidth-1:0] wdata,
   output logic [3:0]           wstrb,
   output logic [DataWidth-1:0] wdata_lane
);

   // Place the right-aligned store data on every lane; strobes pick the live lane(s)
   always_comb begin
      wstrb      = 4'b0000;
      wdata_lane = wdata;
      if (is_write) begin
         case (write_type)
            FUNCT3_SB: begin
               wstrb      = 4'b0001 << addr_lo;
               wdata_lane = {(DataWidth/8){wdata[7:0]}};
            end
            FUNCT3_SH: begin
               // addr_lo[0] is ignored: halfwords always land on an even lane pair
               wstrb      = 4'b0011 << {addr_lo[1], 1'b0};
               wdata_lane = {(DataWidth/16){wdata[15:0]}};
            end
            FUNCT3_SW: wstrb = 4'b1111;
            default:   wstrb = 4'b0000;
         endcase
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU data and instruction accesses onto one memory port, data first.
// Latency: one cycle from request to mem_req_o, then memory latency; commit cycle after last ack.
// Backpressure: stalls the CPU until every pending access has been acked; memory paces via mem_ack_i.
module mem_arbiter
   import cpu_pkg::*;
#(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.master bus
);

   localparam logic [AddrWidth-1:0] WordMask = ~AddrWidth'(3);

   mem_arb_state_t         state, state_nxt;
   logic                   d_done, i_done;
   logic                   d_need, i_need, commit;
   logic                   load_d, load_i, set_d, set_i, cap_d, cap_i;
   logic                   req_we;
   logic [AddrWidth-1:0]   req_addr;
   logic [DataWidth-1:0]   req_wdata;
   logic [3:0]             req_wstrb;
   logic [DataWidth-1:0]   inst_q, rdata_q;
   logic [3:0]             align_strb;
   logic [DataWidth-1:0]   align_wdata;

   assign d_need = (bus.data_read_i | bus.data_write_i) & ~d_done;
   assign i_need = bus.inst_read_i & ~i_done;
   // Nothing left to stall for and something was served: the CPU consumes results now
   assign commit = ~d_need & ~i_need & (d_done | i_done);

   assign bus.stallreq_from_dmem_o = d_need;
   assign bus.stallreq_from_imem_o = i_need;
   assign bus.mem_req_o            = (state != IDLE);
   assign bus.mem_we_o             = req_we;
   assign bus.mem_addr_o           = req_addr;
   assign bus.mem_wdata_o          = req_wdata;
   assign bus.mem_wstrb_o          = req_wstrb;
   assign bus.inst_o               = inst_q;
   assign bus.data_rdata_o         = rdata_q;

   store_align #(.DataWidth(DataWidth)) u_store_align (
      .is_write   (bus.data_write_i),
      .write_type (bus.data_write_type_i),
      .addr_lo    (bus.data_addr_i[1:0]),
      .wdata      (bus.data_wdata_i),
      .wstrb      (align_strb),
      .wdata_lane (align_wdata)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state and per-cycle strobes; a finished access chains straight into the other one
   always_comb begin
      state_nxt = state;
      load_d    = 1'b0;
      load_i    = 1'b0;
      set_d     = 1'b0;
      set_i     = 1'b0;
      cap_d     = 1'b0;
      cap_i     = 1'b0;
      case (state)
         IDLE: begin
            if (d_need) begin
               state_nxt = D_WAIT;
               load_d    = 1'b1;
            end else if (i_need) begin
               state_nxt = I_WAIT;
               load_i    = 1'b1;
            end
         end
         D_WAIT: begin
            if (bus.mem_ack_i) begin
               set_d = 1'b1;
               cap_d = bus.data_read_i;
               if (i_need) begin
                  state_nxt = I_WAIT;
                  load_i    = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         I_WAIT: begin
            if (bus.mem_ack_i) begin
               set_i = 1'b1;
               cap_i = 1'b1;
               if (d_need) begin
                  state_nxt = D_WAIT;
                  load_d    = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request fields are loaded only on entry to a WAIT state, so they hold until the ack
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_we    <= 1'b0;
         req_addr  <= '0;
         req_wdata <= '0;
         req_wstrb <= 4'b0000;
      end else if (load_d) begin
         req_we    <= bus.data_write_i;
         req_addr  <= bus.data_addr_i & WordMask;
         req_wdata <= align_wdata;
         req_wstrb <= align_strb;
      end else if (load_i) begin
         req_we    <= 1'b0;
         req_addr  <= bus.inst_addr_i & WordMask;
         req_wdata <= '0;
         req_wstrb <= 4'b0000;
      end
   end

   // Completion flags: set by ack, cleared together on the commit cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_done <= 1'b0;
         i_done <= 1'b0;
      end else if (commit) begin
         d_done <= 1'b0;
         i_done <= 1'b0;
      end else begin
         if (set_d) d_done <= 1'b1;
         if (set_i) i_done <= 1'b1;
      end
   end

   // Returned words are held until the next capture of the same kind
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_q  <= '0;
         rdata_q <= '0;
      end else begin
         if (cap_i) inst_q  <= bus.mem_rdata_i;
         if (cap_d) rdata_q <= bus.mem_rdata_i;
      end
   end

endmodule
